// File: rtl/core_types.sv
// Shared predecode types: B/BL opcodes, link register index, per-lane decode record.
// Pure definitions, no timing; no handshake of its own.
package core_types;

    localparam int CT_ADDR_W  = 32;
    localparam int CT_GPR_NUM = 32;
    localparam int CT_REG_AW  = $clog2(CT_GPR_NUM);

    localparam logic [5:0]           OPC_B        = 6'b010100;
    localparam logic [5:0]           OPC_BL       = 6'b010101;
    localparam logic [CT_REG_AW-1:0] LINK_REG_IDX = CT_REG_AW'(1);

    typedef struct packed {
        logic                 valid;
        logic                 is_b;
        logic                 is_bl;
        logic [CT_ADDR_W-1:0] target;
        logic [CT_ADDR_W-1:0] link_value;
        logic                 reg_write_valid;
        logic [CT_REG_AW-1:0] reg_write_addr;
    } predecode_lane_t;

    // Word offset {instr[9:0], instr[25:10]} scaled by 4, sign-extended from offs26[25].
    function automatic logic [CT_ADDR_W-1:0] branch_offset(input logic [25:0] offs26);
        return {{(CT_ADDR_W-28){offs26[25]}}, offs26, 2'b00};
    endfunction

endpackage

// File: rtl/branch_predecode_lanes_lane.sv
// Single-lane B/BL decode with target and link computation.
// Combinational, zero latency; no backpressure (pure function of its inputs).
module branch_predecode_lane
    import core_types::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  lane_valid_i,
    input  logic [CT_ADDR_W-1:0]  pc_i,
    input  logic [DATA_WIDTH-1:0] instr_i,
    output predecode_lane_t       dec_o
);

    logic [5:0]  opcode;
    logic [25:0] offs26;

    assign opcode = instr_i[31:26];
    assign offs26 = {instr_i[9:0], instr_i[25:10]};

    always_comb begin
        dec_o                 = '0;
        dec_o.valid           = lane_valid_i;
        dec_o.is_b            = (opcode == OPC_B);
        dec_o.is_bl           = (opcode == OPC_BL);
        dec_o.link_value      = pc_i + CT_ADDR_W'(4);
        dec_o.reg_write_valid = dec_o.is_bl;
        dec_o.reg_write_addr  = dec_o.is_bl ? LINK_REG_IDX : '0;
        if (dec_o.is_b || dec_o.is_bl) begin
            dec_o.target = pc_i + branch_offset(offs26);
        end
    end

endmodule

// File: rtl/branch_predecode_lanes.sv
// Multi-lane B/BL predecode: squashes lanes younger than the first jump and registers a redirect.
// Latency 1 cycle; one valid/ready register, in_ready_o = !out_valid_o || out_ready_i, outputs hold while stalled.
// Optional saturating B/BL counters when BRANCH_PREDECODE_PERF_EN is defined.
module branch_predecode_lanes
    import core_types::*;
#(
    parameter  int DECODE_WIDTH   = 2,
    parameter  int ADDR_WIDTH     = 32,
    parameter  int DATA_WIDTH     = 32,
    parameter  int GPR_NUM        = 32,
    parameter  int PERF_CNT_WIDTH = 32,
    localparam int RAW            = $clog2(GPR_NUM),
    localparam int RLW            = (DECODE_WIDTH > 1) ? $clog2(DECODE_WIDTH) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [DECODE_WIDTH-1:0]        in_lane_valid_i,
    input  logic [DECODE_WIDTH*ADDR_WIDTH-1:0] in_pc_i,
    input  logic [DECODE_WIDTH*DATA_WIDTH-1:0] in_instr_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [DECODE_WIDTH-1:0]        out_lane_valid_o,
    output logic [DECODE_WIDTH-1:0]        out_is_b_o,
    output logic [DECODE_WIDTH-1:0]        out_is_bl_o,
    output logic [DECODE_WIDTH*ADDR_WIDTH-1:0] out_target_o,
    output logic [DECODE_WIDTH*ADDR_WIDTH-1:0] out_link_value_o,
    output logic [DECODE_WIDTH-1:0]        out_reg_write_valid_o,
    output logic [DECODE_WIDTH*RAW-1:0]    out_reg_write_addr_o,
`ifdef BRANCH_PREDECODE_PERF_EN
    output logic [PERF_CNT_WIDTH-1:0]      perf_b_cnt_o,
    output logic [PERF_CNT_WIDTH-1:0]      perf_bl_cnt_o,
`endif
    output logic                           redirect_valid_o,
    output logic [ADDR_WIDTH-1:0]          redirect_pc_o,
    output logic [RLW-1:0]                 redirect_lane_o
);

    predecode_lane_t [DECODE_WIDTH-1:0] dec;
    predecode_lane_t [DECODE_WIDTH-1:0] lane_d, lane_q;
    logic                  hit_d;
    logic [ADDR_WIDTH-1:0] redirect_pc_d, redirect_pc_q;
    logic [RLW-1:0]        redirect_lane_d, redirect_lane_q;
    logic                  redirect_valid_q;
    logic                  out_valid_q;

    for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_lane
        branch_predecode_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .lane_valid_i (in_lane_valid_i[g]),
            .pc_i         (in_pc_i[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .instr_i      (in_instr_i[g*DATA_WIDTH +: DATA_WIDTH]),
            .dec_o        (dec[g])
        );

        assign out_lane_valid_o[g]                         = lane_q[g].valid;
        assign out_is_b_o[g]                               = lane_q[g].is_b;
        assign out_is_bl_o[g]                              = lane_q[g].is_bl;
        assign out_target_o[g*ADDR_WIDTH +: ADDR_WIDTH]     = lane_q[g].target;
        assign out_link_value_o[g*ADDR_WIDTH +: ADDR_WIDTH] = lane_q[g].link_value;
        assign out_reg_write_valid_o[g]                    = lane_q[g].reg_write_valid;
        assign out_reg_write_addr_o[g*RAW +: RAW]           = lane_q[g].reg_write_addr;
    end

    // Lane 0 is oldest: the first valid jump wins, everything younger is dropped.
    always_comb begin
        lane_d          = dec;
        hit_d           = 1'b0;
        redirect_pc_d   = '0;
        redirect_lane_d = '0;
        for (int l = 0; l < DECODE_WIDTH; l++) begin
            if (hit_d || !dec[l].valid) begin
                lane_d[l].valid           = 1'b0;
                lane_d[l].is_b            = 1'b0;
                lane_d[l].is_bl           = 1'b0;
                lane_d[l].reg_write_valid = 1'b0;
                lane_d[l].reg_write_addr  = '0;
            end else if (dec[l].is_b || dec[l].is_bl) begin
                hit_d           = 1'b1;
                redirect_pc_d   = dec[l].target;
                redirect_lane_d = RLW'(l);
            end
        end
    end

    assign in_ready_o = !out_valid_q || out_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q      <= 1'b0;
            lane_q           <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            redirect_lane_q  <= '0;
        end else if (flush_i) begin
            out_valid_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
        end else if (in_ready_o) begin
            out_valid_q      <= in_valid_i;
            redirect_valid_q <= in_valid_i && hit_d;
            if (in_valid_i) begin
                lane_q          <= lane_d;
                redirect_pc_q   <= redirect_pc_d;
                redirect_lane_q <= redirect_lane_d;
            end
        end
    end

    assign out_valid_o      = out_valid_q;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign redirect_lane_o  = redirect_lane_q;

`ifdef BRANCH_PREDECODE_PERF_EN
    logic [PERF_CNT_WIDTH-1:0] perf_b_d, perf_b_q, perf_bl_d, perf_bl_q;
    logic [PERF_CNT_WIDTH:0]   b_sum, bl_sum;
    logic                      fire;

    assign fire = out_valid_q && out_ready_i && !flush_i;

    always_comb begin
        b_sum  = {1'b0, perf_b_q};
        bl_sum = {1'b0, perf_bl_q};
        for (int l = 0; l < DECODE_WIDTH; l++) begin
            b_sum  = b_sum  + {{PERF_CNT_WIDTH{1'b0}}, lane_q[l].is_b};
            bl_sum = bl_sum + {{PERF_CNT_WIDTH{1'b0}}, lane_q[l].is_bl};
        end
        perf_b_d  = perf_b_q;
        perf_bl_d = perf_bl_q;
        if (fire) begin
            perf_b_d  = b_sum[PERF_CNT_WIDTH]  ? '1 : b_sum[PERF_CNT_WIDTH-1:0];
            perf_bl_d = bl_sum[PERF_CNT_WIDTH] ? '1 : bl_sum[PERF_CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_b_q  <= '0;
            perf_bl_q <= '0;
        end else begin
            perf_b_q  <= perf_b_d;
            perf_bl_q <= perf_bl_d;
        end
    end

    assign perf_b_cnt_o  = perf_b_q;
    assign perf_bl_cnt_o = perf_bl_q;
`endif

endmodule

// File: tb/tb_branch_predecode_lanes.sv
// Bench for branch_predecode_lanes: fixed vectors, handshake corner sequences and random traffic vs a cycle model.
// Outputs sampled 1 time unit after the rising edge; inputs driven with blocking assignments.
module tb_branch_predecode_lanes;

    localparam int DW  = 2;
    localparam int AW  = 32;
    localparam int IW  = 32;
    localparam int RAW = 5;
    localparam int PCW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush_i = 1'b0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [DW-1:0]     in_lane_valid_i = '0;
    logic [DW*AW-1:0]  in_pc_i = '0;
    logic [DW*IW-1:0]  in_instr_i = '0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic [DW-1:0]     out_lane_valid_o, out_is_b_o, out_is_bl_o, out_reg_write_valid_o;
    logic [DW*AW-1:0]  out_target_o, out_link_value_o;
    logic [DW*RAW-1:0] out_reg_write_addr_o;
    logic              redirect_valid_o;
    logic [AW-1:0]     redirect_pc_o;
    logic [0:0]        redirect_lane_o;
`ifdef BRANCH_PREDECODE_PERF_EN
    logic [PCW-1:0]    perf_b_cnt_o, perf_bl_cnt_o;
`endif

    always #5 clk = ~clk;

    branch_predecode_lanes #(
        .DECODE_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_WIDTH(IW), .GPR_NUM(32), .PERF_CNT_WIDTH(PCW)
    ) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_lane_valid_i(in_lane_valid_i), .in_pc_i(in_pc_i), .in_instr_i(in_instr_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_lane_valid_o(out_lane_valid_o), .out_is_b_o(out_is_b_o), .out_is_bl_o(out_is_bl_o),
        .out_target_o(out_target_o), .out_link_value_o(out_link_value_o),
        .out_reg_write_valid_o(out_reg_write_valid_o), .out_reg_write_addr_o(out_reg_write_addr_o),
`ifdef BRANCH_PREDECODE_PERF_EN
        .perf_b_cnt_o(perf_b_cnt_o), .perf_bl_cnt_o(perf_bl_cnt_o),
`endif
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .redirect_lane_o(redirect_lane_o)
    );

    typedef struct {
        logic        ov;
        logic [1:0]  lv, isb, isbl, rwv;
        logic [9:0]  rwa;
        logic [63:0] tgt, link;
        logic        rv;
        logic [31:0] rpc;
        logic        rl;
    } exp_t;

    typedef struct {
        logic [1:0]  lv;
        logic [63:0] pcs, ins;
        exp_t        e;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    logic mv = 1'b0;
    exp_t mexp;
    longint perf_b_m = 0, perf_bl_m = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: decode each lane from the instruction word arithmetic, oldest jump wins.
    function automatic exp_t model(input logic [1:0] lv, input logic [63:0] pcs, input logic [63:0] ins);
        exp_t e;
        bit   jumped = 0;
        e = '{default: '0};
        e.ov = 1'b1;
        for (int l = 0; l < DW; l++) begin
            longint unsigned pc  = longint'(pcs[l*32 +: 32]);
            longint unsigned in  = longint'(ins[l*32 +: 32]);
            longint unsigned op  = in >> 26;
            longint          off = longint'(((in & 64'h3ff) << 16) | ((in >> 10) & 64'hffff));
            longint          t;
            bit              isj;
            if (off >= (64'd1 << 25)) off = off - (64'd1 << 26);
            t   = longint'(pc) + off * 4;
            isj = (op == 20) || (op == 21);
            if (lv[l] && !jumped) begin
                e.lv[l]           = 1'b1;
                e.isb[l]          = (op == 20);
                e.isbl[l]         = (op == 21);
                e.rwv[l]          = (op == 21);
                e.rwa[l*5 +: 5]   = (op == 21) ? 5'd1 : 5'd0;
                e.link[l*32 +: 32] = 32'(pc + 4);
                e.tgt[l*32 +: 32]  = isj ? 32'(t) : 32'd0;
                if (isj) begin
                    jumped = 1;
                    e.rv   = 1'b1;
                    e.rpc  = 32'(t);
                    e.rl   = 1'(l);
                end
            end
        end
        return e;
    endfunction

    task automatic check_out(input string tag, input exp_t e);
        chk({tag, ".out_valid"}, 64'(out_valid_o), 64'(e.ov));
        chk({tag, ".redir_valid"}, 64'(redirect_valid_o), 64'(e.rv));
        if (e.ov) begin
            chk({tag, ".lane_valid"}, 64'(out_lane_valid_o), 64'(e.lv));
            chk({tag, ".is_b"}, 64'(out_is_b_o), 64'(e.isb));
            chk({tag, ".is_bl"}, 64'(out_is_bl_o), 64'(e.isbl));
            chk({tag, ".rw_valid"}, 64'(out_reg_write_valid_o), 64'(e.rwv));
            chk({tag, ".rw_addr"}, 64'(out_reg_write_addr_o), 64'(e.rwa));
            if (e.rv) begin
                chk({tag, ".redir_pc"}, 64'(redirect_pc_o), 64'(e.rpc));
                chk({tag, ".redir_lane"}, 64'(redirect_lane_o), 64'(e.rl));
            end
            for (int l = 0; l < DW; l++) begin
                if (e.lv[l]) begin
                    chk($sformatf("%s.target%0d", tag, l), 64'(out_target_o[l*32 +: 32]), 64'(e.tgt[l*32 +: 32]));
                    chk($sformatf("%s.link%0d", tag, l), 64'(out_link_value_o[l*32 +: 32]), 64'(e.link[l*32 +: 32]));
                end
            end
        end
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl,
                         input logic [1:0] lv, input logic [63:0] pcs, input logic [63:0] ins);
        in_valid_i      = iv;
        out_ready_i     = ordy;
        flush_i         = fl;
        in_lane_valid_i = lv;
        in_pc_i         = pcs;
        in_instr_i      = ins;
    endtask

    // One clock of the handshake model; called just after an edge with inputs already driven.
    task automatic step(input string tag);
        logic ir;
        exp_t cur;
        #1;
        ir = !mv || out_ready_i;
        chk({tag, ".in_ready"}, 64'(in_ready_o), 64'(ir));
        if (mv && out_ready_i && !flush_i) begin
            perf_b_m  = perf_b_m + $countones(mexp.isb);
            perf_bl_m = perf_bl_m + $countones(mexp.isbl);
            if (perf_b_m > 64'hffffffff) perf_b_m = 64'hffffffff;
            if (perf_bl_m > 64'hffffffff) perf_bl_m = 64'hffffffff;
        end
        if (flush_i) mv = 1'b0;
        else if (ir) begin
            if (in_valid_i) mexp = model(in_lane_valid_i, in_pc_i, in_instr_i);
            mv = in_valid_i;
        end
        @(posedge clk);
        #1;
        cur    = mexp;
        cur.ov = mv;
        cur.rv = mv && mexp.rv;
        check_out(tag, cur);
`ifdef BRANCH_PREDECODE_PERF_EN
        chk({tag, ".perf_b"}, 64'(perf_b_cnt_o), 64'(perf_b_m));
        chk({tag, ".perf_bl"}, 64'(perf_bl_cnt_o), 64'(perf_bl_m));
`endif
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 2))
            0: r[31:26] = 6'b010100;
            1: r[31:26] = 6'b010101;
            default: ;
        endcase
        return r;
    endfunction

    vec_t tbl[7];
    logic [63:0] bp_a_ins, bp_b_ins;

    initial begin
        mexp = '{default: '0};
        tbl[0] = '{2'b11, {32'h1c000004, 32'h1c000000}, {32'h00000000, 32'h50000800},
                   '{1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 10'h000, {32'h0, 32'h1c000008},
                     {32'h0, 32'h1c000004}, 1'b1, 32'h1c000008, 1'b0}};
        tbl[1] = '{2'b11, {32'h1c000010, 32'h1c00000c}, {32'h57ffffff, 32'h00000000},
                   '{1'b1, 2'b11, 2'b00, 2'b10, 2'b10, 10'h020, {32'h1c00000c, 32'h0},
                     {32'h1c000014, 32'h1c000010}, 1'b1, 32'h1c00000c, 1'b1}};
        tbl[2] = '{2'b00, {32'h00001004, 32'h00001000}, {32'h50000800, 32'h54000001},
                   '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 10'h000, 64'h0, 64'h0, 1'b0, 32'h0, 1'b0}};
        tbl[3] = '{2'b11, {32'h00002008, 32'h00002000}, {32'h50000800, 32'h54000001},
                   '{1'b1, 2'b01, 2'b00, 2'b01, 2'b01, 10'h001, {32'h0, 32'h00042000},
                     {32'h0, 32'h00002004}, 1'b1, 32'h00042000, 1'b0}};
        tbl[4] = '{2'b10, {32'hfffffffc, 32'h00003000}, {32'h50000800, 32'h50000800},
                   '{1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 10'h000, {32'h00000004, 32'h0},
                     {32'h00000000, 32'h0}, 1'b1, 32'h00000004, 1'b1}};
        tbl[5] = '{2'b11, {32'h10000004, 32'h10000000}, {32'hfc000000, 32'h50000200},
                   '{1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 10'h000, {32'h0, 32'h08000000},
                     {32'h0, 32'h10000004}, 1'b1, 32'h08000000, 1'b0}};
        tbl[6] = '{2'b11, {32'h00000104, 32'h00000100}, {32'h4c000000, 32'h58000000},
                   '{1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 10'h000, 64'h0,
                     {32'h00000108, 32'h00000104}, 1'b0, 32'h0, 1'b0}};

        // Reset state
        #12;
        chk("rst.out_valid", 64'(out_valid_o), 64'd0);
        chk("rst.in_ready", 64'(in_ready_o), 64'd1);
        chk("rst.redir_valid", 64'(redirect_valid_o), 64'd0);
        chk("rst.redir_pc", 64'(redirect_pc_o), 64'd0);
        chk("rst.redir_lane", 64'(redirect_lane_o), 64'd0);
        chk("rst.lane_valid", 64'(out_lane_valid_o), 64'd0);
        chk("rst.target", out_target_o, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 1'b0, tbl[i].lv, tbl[i].pcs, tbl[i].ins);
            step($sformatf("tbl%0d", i));
            check_out($sformatf("tbl%0d.fixed", i), tbl[i].e);
        end

        // Backpressure: bundle B waits three stalled cycles, then appears exactly once.
        bp_a_ins = {32'h0, 32'h50000800};
        bp_b_ins = {32'h0, 32'h54000001};
        drive(1'b1, 1'b1, 1'b0, 2'b01, {32'h0, 32'h00005000}, bp_a_ins);
        step("bp.load_a");
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 1'b0, 2'b01, {32'h0, 32'h00006000}, bp_b_ins);
            step($sformatf("bp.stall%0d", c));
            chk($sformatf("bp.stall%0d.ready_low", c), 64'(in_ready_o), 64'd0);
            chk($sformatf("bp.stall%0d.hold_a", c), 64'(out_target_o[31:0]), 64'h00005008);
        end
        drive(1'b1, 1'b1, 1'b0, 2'b01, {32'h0, 32'h00006000}, bp_b_ins);
        step("bp.release");
        chk("bp.b_target", 64'(out_target_o[31:0]), 64'h00046000);
        drive(1'b0, 1'b1, 1'b0, 2'b00, 64'h0, 64'h0);
        step("bp.drain");
        chk("bp.drained", 64'(out_valid_o), 64'd0);

        // Flush beats a simultaneous accept.
        drive(1'b1, 1'b1, 1'b1, 2'b01, {32'h0, 32'h00007000}, bp_a_ins);
        step("flush.accept");
        chk("flush.out_valid", 64'(out_valid_o), 64'd0);
        chk("flush.redir_valid", 64'(redirect_valid_o), 64'd0);

        // Async reset mid-stall clears before the next edge.
        drive(1'b1, 1'b1, 1'b0, 2'b01, {32'h0, 32'h00008000}, bp_a_ins);
        step("arst.load");
        drive(1'b1, 1'b0, 1'b0, 2'b01, {32'h0, 32'h00009000}, bp_b_ins);
        step("arst.stall");
        chk("arst.before", 64'(out_valid_o), 64'd1);
        rst = 1'b1;
        #1;
        chk("arst.out_valid", 64'(out_valid_o), 64'd0);
        chk("arst.in_ready", 64'(in_ready_o), 64'd1);
        chk("arst.redir_valid", 64'(redirect_valid_o), 64'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mv        = 1'b0;
        perf_b_m  = 0;
        perf_bl_m = 0;

`ifdef BRANCH_PREDECODE_PERF_EN
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 1'b1, 1'b0, 2'b01, {32'h0, 32'(c * 16)}, {32'h0, 32'h54000001});
            step($sformatf("perf.bl%0d", c));
        end
        drive(1'b0, 1'b1, 1'b0, 2'b00, 64'h0, 64'h0);
        step("perf.drain");
        chk("perf.bl_five", 64'(perf_bl_cnt_o), 64'd5);
`endif

        for (int c = 0; c < 400; c++) begin
            logic [63:0] pcs;
            pcs = {$urandom, $urandom};
            pcs[1:0]   = 2'b00;
            pcs[33:32] = 2'b00;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                  2'($urandom), pcs, {rand_instr(), rand_instr()});
            step($sformatf("rnd%0d", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
